// File: rtl/axis_qam_pkg.sv
// Shared mode encoding and elaboration-time helpers for the QAM mapper.
package axis_qam_pkg;

  localparam logic [1:0] MOD_BPSK   = 2'd0;
  localparam logic [1:0] MOD_QPSK   = 2'd1;
  localparam logic [1:0] MOD_QAM16  = 2'd2;
  localparam logic [1:0] MOD_QAM256 = 2'd3;

  // Per-axis Gray bit count selector for the PAM mapper
  typedef enum logic [1:0] {K1 = 2'd0, K2 = 2'd1, K4 = 2'd2} ksel_e;

  function automatic logic [3:0] bps_of(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 4'd1;
      MOD_QPSK:  return 4'd2;
      MOD_QAM16: return 4'd4;
      default:   return 4'd8;
    endcase
  endfunction

  function automatic logic [5:0] spw_of(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return 6'd32;
      MOD_QPSK:  return 6'd16;
      MOD_QAM16: return 6'd8;
      default:   return 6'd4;
    endcase
  endfunction

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic int step_of(input int amp, input int k);
    return (k == 1) ? amp : (k == 2) ? amp / 3 : amp / 15;
  endfunction

endpackage

// File: rtl/pam_gray_level.sv
// Combinational Gray-coded PAM level: ((2^k-1) - 2*gray2bin(g)) * STEP_k.
module pam_gray_level
  import axis_qam_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AMP = 2**(DW-2)
) (
  input  ksel_e                  i_ksel,
  input  logic [3:0]             i_g,
  output logic signed [DW-1:0]   o_level
);

  localparam logic signed [DW-1:0] STEP1 = DW'(step_of(AMP, 1));
  localparam logic signed [DW-1:0] STEP2 = DW'(step_of(AMP, 2));
  localparam logic signed [DW-1:0] STEP4 = DW'(step_of(AMP, 4));

  logic [3:0]            w_n;
  logic [DW-1:0]         w_max;
  logic signed [DW-1:0]  w_step;
  logic signed [DW-1:0]  w_odd;

  always_comb begin
    w_n    = '0;
    w_max  = '0;
    w_step = '0;
    case (i_ksel)
      K1: begin w_n = {3'b0, i_g[0]};                 w_max = DW'(1);  w_step = STEP1; end
      K2: begin w_n = gray2bin({2'b0, i_g[1:0]});     w_max = DW'(3);  w_step = STEP2; end
      K4: begin w_n = gray2bin(i_g);                  w_max = DW'(15); w_step = STEP4; end
      default: ;
    endcase
    // Odd integer in [-(2^k-1), 2^k-1]; all-zeros Gray gives the top level
    w_odd   = $signed(w_max) - $signed(DW'({w_n, 1'b0}));
    o_level = w_odd * w_step;
  end

endmodule

// File: rtl/axis_qam_mapper.sv
// AXI4-Stream constellation mapper: 32-bit words in, one Gray-coded {Q,I} per beat out.
module axis_qam_mapper
  import axis_qam_pkg::*;
#(
  parameter int DW  = 16,
  parameter int AMP = 2**(DW-2)
) (
  input  logic            aclk,
  input  logic            aresetn,
  output logic            s_axis_tready,
  input  logic [31:0]     s_axis_tdata,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  input  logic            m_axis_tready,
  output logic [2*DW-1:0] m_axis_tdata,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  input  logic [1:0]      mod_type,
  output logic [1:0]      frame_mode
);

  logic [31:0]     r_word;
  logic            r_last;
  logic            r_hold;
  logic [4:0]      r_sym_idx;
  logic            r_frame_start;
  logic [1:0]      r_mode;
  logic [2*DW-1:0] r_tdata;
  logic            r_tvalid;
  logic            r_tlast;

  logic            w_out_adv;
  logic [4:0]      w_spw_m1;
  logic            w_last_sym;
  logic            w_accept;
  logic [4:0]      w_shift;
  logic [7:0]      w_bits;
  ksel_e           w_ksel;
  logic [1:0][3:0]    w_g;
  logic [1:0][DW-1:0] w_lvl;
  logic [DW-1:0]      w_q;

  assign w_out_adv     = ~r_tvalid | m_axis_tready;
  assign w_spw_m1      = 5'(spw_of(r_mode) - 6'd1);
  assign w_last_sym    = (r_sym_idx == w_spw_m1);
  assign s_axis_tready = ~r_hold | (w_last_sym & w_out_adv);
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign frame_mode    = r_mode;

  always_comb begin
    w_shift = '0;
    w_ksel  = K1;
    w_g     = '0;
    case (r_mode)
      MOD_BPSK:  begin w_shift = r_sym_idx;                w_ksel = K1; end
      MOD_QPSK:  begin w_shift = {r_sym_idx[3:0], 1'b0};   w_ksel = K1; end
      MOD_QAM16: begin w_shift = {r_sym_idx[2:0], 2'b00};  w_ksel = K2; end
      default:   begin w_shift = {r_sym_idx[1:0], 3'b000}; w_ksel = K4; end
    endcase
    w_bits = 8'(r_word >> w_shift);
    case (r_mode)
      MOD_BPSK:  begin w_g[0] = {3'b0, w_bits[0]}; w_g[1] = '0;                 end
      MOD_QPSK:  begin w_g[0] = {3'b0, w_bits[0]}; w_g[1] = {3'b0, w_bits[1]};  end
      MOD_QAM16: begin w_g[0] = {2'b0, w_bits[1:0]}; w_g[1] = {2'b0, w_bits[3:2]}; end
      default:   begin w_g[0] = w_bits[3:0];       w_g[1] = w_bits[7:4];        end
    endcase
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    pam_gray_level #(.DW(DW), .AMP(AMP)) u_pam (
      .i_ksel  (w_ksel),
      .i_g     (w_g[a]),
      .o_level (w_lvl[a])
    );
  end

  // BPSK is real-only; the Q mapper output is ignored
  assign w_q = (r_mode == MOD_BPSK) ? '0 : w_lvl[1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_word        <= '0;
      r_last        <= 1'b0;
      r_hold        <= 1'b0;
      r_sym_idx     <= '0;
      r_frame_start <= 1'b1;
      r_mode        <= MOD_BPSK;
    end else if (w_accept) begin
      r_word        <= s_axis_tdata;
      r_last        <= s_axis_tlast;
      r_hold        <= 1'b1;
      r_sym_idx     <= '0;
      r_frame_start <= s_axis_tlast;
      if (r_frame_start) r_mode <= mod_type;
    end else if (r_hold && w_out_adv) begin
      if (w_last_sym) begin
        r_hold    <= 1'b0;
        r_sym_idx <= '0;
      end else begin
        r_sym_idx <= r_sym_idx + 5'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_out_adv) begin
      r_tvalid <= r_hold;
      if (r_hold) begin
        r_tdata <= {w_q, w_lvl[0]};
        r_tlast <= r_last & w_last_sym;
      end
    end
  end

endmodule

// File: tb/tb_axis_qam_mapper.sv
// Randomized self-checking bench for axis_qam_mapper against a behavioural symbol model.
module tb_axis_qam_mapper;

  localparam int DW  = 16;
  localparam int AMP = 16384;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic        aclk, aresetn;
  logic        s_tready, s_tvalid, s_tlast;
  logic [31:0] s_tdata;
  logic        m_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [1:0]  mod_type, frame_mode;

  int checks = 0;
  int errors = 0;

  beat_t got_q[$];
  int    got_cyc[$];
  beat_t exp_q[$];
  int    cyc = 0;
  int    stall_viol = 0;
  bit    pstall = 0;
  logic [31:0] pdata;
  logic        plast;
  bit    bp_en = 0;

  bit        mdl_start = 1;
  logic [1:0] mdl_mode = 0;

  axis_qam_mapper #(.DW(DW), .AMP(AMP)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .mod_type      (mod_type),
    .frame_mode    (frame_mode)
  );

  initial aclk = 0;
  always #5 aclk = ~aclk;

  // Record accepted output beats and watch stall stability
  always @(negedge aclk) begin
    beat_t b;
    cyc++;
    if (!aresetn) pstall = 0;
    else begin
      if (pstall && (m_tvalid !== 1'b1 || m_tdata !== pdata || m_tlast !== plast)) stall_viol++;
      if (m_tvalid && m_tready) begin
        b.d = m_tdata; b.l = m_tlast;
        got_q.push_back(b);
        got_cyc.push_back(cyc);
      end
      pstall = m_tvalid && !m_tready;
      pdata  = m_tdata;
      plast  = m_tlast;
    end
  end

  always @(posedge aclk) begin
    #1;
    if (bp_en) m_tready = ($urandom_range(0, 1) == 1);
  end

  // Gray-coded PAM level straight from the mapping rule
  function automatic int ref_level(input int g, input int k);
    int n = 0;
    for (int s = 0; s < k; s++) n = n ^ (g >> s);
    return ((1 << k) - 1 - 2 * n) * (AMP / ((1 << k) - 1));
  endfunction

  function automatic void model_word(input logic [31:0] d, input logic l, input logic [1:0] m);
    int bps, spw, k, b, iv, qv;
    beat_t e;
    if (mdl_start) mdl_mode = m;
    mdl_start = l;
    bps = 1 << mdl_mode;
    spw = 32 / bps;
    k   = (mdl_mode == 3) ? 4 : (mdl_mode == 2) ? 2 : 1;
    for (int s = 0; s < spw; s++) begin
      b = int'((d >> (s * bps)) & ((64'd1 << bps) - 1));
      if (mdl_mode == 0) begin iv = ref_level(b, 1); qv = 0; end
      else begin iv = ref_level(b & ((1 << k) - 1), k); qv = ref_level(b >> k, k); end
      e.d = {qv[15:0], iv[15:0]};
      e.l = l && (s == spw - 1);
      exp_q.push_back(e);
    end
  endfunction

  function automatic void clear_q();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l, input logic [1:0] m);
    bit acc = 0;
    int n = 0;
    s_tdata = d; s_tlast = l; s_tvalid = 1; mod_type = m;
    while (!acc && n < 2000) begin
      @(negedge aclk); acc = s_tready;
      @(posedge aclk); #1; n++;
    end
    s_tvalid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout word %h not accepted", d);
    end
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (got_q.size() < n && t < 20000) begin @(posedge aclk); t++; end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 0; s_tvalid = 0; s_tlast = 0; s_tdata = 0; mod_type = 0; m_tready = 1;
    #12;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_tlast); end
    checks++; if (frame_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d want 0", frame_mode); end
    @(negedge aclk); aresetn = 1; #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b want 1", s_tready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_bpsk();
    clear_q();
    model_word(32'h00000001, 1, 0);
    send_word(32'h00000001, 1, 0);
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bpsk_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bpsk_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
    if (got_q.size() >= 32) begin
      checks++; if (got_q[0].d !== 32'h0000C000) begin errors++; $display("FAIL bpsk_beat0 got %h want 0000c000", got_q[0].d); end
      checks++; if (got_q[31] !== beat_t'({32'h00004000, 1'b1})) begin errors++; $display("FAIL bpsk_beat31 got %h/%b want 00004000/1", got_q[31].d, got_q[31].l); end
    end
  endtask

  task automatic test_qpsk();
    clear_q();
    model_word(32'hFFFFFFFF, 1, 1);
    send_word(32'hFFFFFFFF, 1, 1);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL qpsk_latency_early got %b want 0", m_tvalid); end
    @(posedge aclk); #1;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hC000C000) begin errors++; $display("FAIL qpsk_first got %b/%h want 1/c000c000", m_tvalid, m_tdata); end
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL qpsk_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL qpsk_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  task automatic test_qam16();
    clear_q();
    model_word(32'h00000002, 1, 2);
    send_word(32'h00000002, 1, 2);
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL qam16_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL qam16_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
    if (got_q.size() >= 2) begin
      checks++; if (got_q[0].d !== 32'h3FFFC001) begin errors++; $display("FAIL qam16_beat0 got %h want 3fffc001", got_q[0].d); end
      checks++; if (got_q[1].d !== 32'h3FFF3FFF) begin errors++; $display("FAIL qam16_beat1 got %h want 3fff3fff", got_q[1].d); end
    end
  endtask

  task automatic test_qam256();
    clear_q();
    model_word(32'h000000FF, 1, 3);
    send_word(32'h000000FF, 1, 3);
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL qam256_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL qam256_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
    if (got_q.size() >= 4) begin
      checks++; if (got_q[0].d !== 32'hEAACEAAC) begin errors++; $display("FAIL qam256_beat0 got %h want eaaceaac", got_q[0].d); end
      checks++; if (got_q[3] !== beat_t'({32'h3FFC3FFC, 1'b1})) begin errors++; $display("FAIL qam256_beat3 got %h/%b want 3ffc3ffc/1", got_q[3].d, got_q[3].l); end
    end
  endtask

  task automatic test_mode_switch();
    logic [31:0] w0, w1, w2;
    clear_q();
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    model_word(w0, 0, 1); model_word(w1, 1, 0); model_word(w2, 1, 0);
    send_word(w0, 0, 1);
    send_word(w1, 1, 0);
    checks++; if (frame_mode !== 2'd1) begin errors++; $display("FAIL switch_mode_held got %0d want 1", frame_mode); end
    send_word(w2, 1, 0);
    checks++; if (frame_mode !== 2'd0) begin errors++; $display("FAIL switch_mode_next got %0d want 0", frame_mode); end
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL switch_count got %0d want 64", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL switch_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1;
    clear_q();
    w0 = $urandom; w1 = $urandom;
    model_word(w0, 0, 1); model_word(w1, 1, 1);
    send_word(w0, 0, 1);
    send_word(w1, 1, 1);
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
    if (got_cyc.size() >= 32) begin
      checks++; if (got_cyc[31] - got_cyc[0] !== 31) begin errors++; $display("FAIL b2b_gap span %0d want 31", got_cyc[31] - got_cyc[0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic l;
    logic [1:0] m;
    clear_q();
    stall_viol = 0;
    bp_en = 1;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      l = (i == 99) || ($urandom_range(0, 3) == 0);
      m = 2'($urandom_range(0, 3));
      model_word(d, l, m);
      send_word(d, l, m);
    end
    wait_beats(exp_q.size());
    bp_en = 0;
    @(posedge aclk); #1;
    m_tready = 1;
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d violations want 0", stall_viol); end
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_word($urandom, 0, 1);
    repeat (4) @(posedge aclk);
    #2 aresetn = 0;
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", m_tvalid); end
    checks++; if (frame_mode !== 2'd0) begin errors++; $display("FAIL rstmid_mode got %0d want 0", frame_mode); end
    @(negedge aclk); aresetn = 1; #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rstmid_tready got %b want 1", s_tready); end
    @(posedge aclk); #1;
    clear_q();
    mdl_start = 1;
    model_word(32'h000000FF, 1, 3);
    send_word(32'h000000FF, 1, 3);
    wait_beats(exp_q.size());
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rstmid_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_beat %0d got %h/%b want %h/%b", i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l); end
    end
  endtask

  initial begin
    test_reset();
    test_bpsk();
    test_qpsk();
    test_qam16();
    test_qam256();
    test_mode_switch();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
